neuron_accumulator: RTL and testbench
=====================================

# neuron_accumulator

Downstream stage of the accelerator control FSM. It takes the 16 parallel products from the PE array each time the FSM fires a MAC group, reduces them in a pipelined adder tree, and accumulates partial sums across groups. On `neuron_done` it rescales the neuron result, rounds and saturates it, then queues it for BRAM write-back at the output address the FSM presents.

## Interface
- `NUM_PE`, 16: products per group; must be a power of two.
- `DATA_W`, 16: width of the result word; each product is 2*DATA_W wide.
- `FRAC_BITS`, 8: fractional bits of operands. Products carry 2*FRAC_BITS fractional bits.
- `ACC_W`, 42: accumulator width (signed, saturating).
- `ADDR_W`, 16: BRAM address width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `products_in` in NUM_PE×2*DATA_W: signed products, sampled when `prod_valid`=1.
- `prod_valid` in 1: one MAC group is present this cycle.
- `neuron_done` in 1: closes the current neuron after any group sampled in the same cycle.
- `out_addr` in ADDR_W: write address, sampled with `neuron_done`.
- `acc_ready` out 1: low while the write-back FIFO is full.
- `bram_wr_en` out 1: write request, high whenever the FIFO is non-empty.
- `bram_wr_addr` out ADDR_W: head-entry address.
- `bram_wr_data` out DATA_W: head-entry result.
- `bram_wr_ready` in 1: BRAM accepts the head entry this cycle.
- `busy` out 1: any tree stage is occupied, or the accumulator holds an open neuron, or the FIFO is non-empty.
- `err_overflow` out 1: sticky; a result was dropped because the FIFO was full.

## Operation
- **Tree:** log2(NUM_PE)=4 registered stages (16→8→4→2→1). Each stage grows one bit, so the output is 2*DATA_W+4 bits, sign-extended to ACC_W.
- **Control:** each stage carries a `valid` bit, a `close` bit and the captured `out_addr`. A sample with both `prod_valid` and `neuron_done` carries both bits.
- **Accumulation at tree exit:**
  - acc_next = sat_ACC_W(acc + (valid ? sum : 0)).
  - If `close`=1, finalize acc_next and clear acc to 0 in the same cycle.
  - Otherwise acc <= acc_next.
  - Saturation clamps to ±(2^(ACC_W-1)) bounds; the accumulator never wraps.
- **Finalize:**
  - r = (acc_next + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift with round-half-up.
  - Saturate r to signed DATA_W (0x7FFF / 0x8000).
  - Apply the optional ReLU (see Configuration).
  - Push {addr, r} into the write-back FIFO.
- **Write-back FIFO:** 2 entries.
  - Pop when `bram_wr_en` && `bram_wr_ready`.
  - A push and a pop in the same cycle are both accepted, even when the FIFO is full.
  - A push into a full FIFO with no pop drops the entry and sets `err_overflow`. It stays set until reset.
- **Empty close:** `neuron_done` with no prior groups writes 0.
- **Upstream contract:** the FSM must hold off new groups while `acc_ready`=0. The block does not backpressure the tree.

## Timing
- All outputs reset to 0: `acc_ready` resets to 1 once `rst` is released; everything else is 0. Internal state (tree stages, acc, FIFO pointers) resets to 0.
- Reset asserted mid-operation clears everything asynchronously. In-flight groups and queued results are lost, and no write is issued.
- Group sampled at edge T: sum is in the stage-4 register after edge T+3, and accumulated at edge T+4.
- Close sampled at edge T: FIFO push at edge T+4. `bram_wr_en`, `bram_wr_addr` and `bram_wr_data` are valid in the cycle after edge T+4, provided the FIFO was empty.
- Throughput: one group per cycle. Back-to-back neurons are allowed, with a close one cycle and the next group the following cycle.
- Output signals stay stable while `bram_wr_en`=1 and `bram_wr_ready`=0.
- `acc_ready` is registered: it falls the cycle after the FIFO becomes full, and rises the cycle after a pop.

## Configuration
- `NEURON_ACC_RELU_EN`:
  - Defined: finalized results with r<0 are written as 0, applied after saturation.
  - Undefined: the signed saturated r is written unchanged.

## Test plan
- **Single group:**
  - Stimulus: all 16 products 0x00010000 (1.0×1.0), `prod_valid` and `neuron_done` together, `out_addr`=0x0010, `bram_wr_ready`=1.
  - Response: one write, addr 0x0010, data 0x1000, `bram_wr_en` high in the cycle after edge T+4.
- **Multi-group:**
  - Stimulus: 4 groups of products 0x00000100 each, then `neuron_done` alone with `out_addr`=0x0003.
  - Response: data 0x0040 (64×256=16384, then >>8 = 64), exactly one write.
- **Saturation/ReLU:**
  - Stimulus: 16 products of 0x7FFF0000 in one group.
  - Response: data 0x7FFF.
  - Stimulus: all products −0x00010000.
  - Response: 0x0000 with the macro defined; 0xF000 without it.
- **Backpressure:**
  - Stimulus: `bram_wr_ready`=0, three consecutive one-group neurons.
  - Response: `acc_ready` falls after the second push; the third is dropped; `err_overflow`=1. After `bram_wr_ready`=1, exactly two writes occur, in order.
- **Reset mid-neuron:**
  - Stimulus: 2 groups, then `rst`=0 for 1 cycle, then a new neuron of 1 group of 0x00010000 products.
  - Response: no write from the aborted neuron; the new neuron writes 0x1000.
- **Rounding:**
  - Stimulus: a single product of 0x00000080, the rest 0.
  - Response: data 0x0001 (0x80 + 0x80 = 0x100, then >>8 = 1).
  - Stimulus: a single product of 0x0000007F, the rest 0.
  - Response: data 0x0000.

Source files
------------

// File: rtl/neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : neuron_accumulator
// Purpose  : Reduces NUM_PE signed products per MAC group through a registered
//            adder tree, accumulates partial sums across groups with
//            saturation, and on neuron close rescales, rounds and saturates
//            the result before queueing it in a 2-entry BRAM write-back FIFO.
// Options  : NEURON_ACC_RELU_EN - when defined, negative results are written
//            as zero (applied after saturation).
// Revision : 1.0 - initial release
// ============================================================================
module neuron_accumulator #(
   parameter int NUM_PE    = 16,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8,
   parameter int ACC_W     = 42,
   parameter int ADDR_W    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_PE*2*DATA_W-1:0]   products_in,
   input  logic                         prod_valid,
   input  logic                         neuron_done,
   input  logic [ADDR_W-1:0]            out_addr,
   output logic                         acc_ready,
   output logic                         bram_wr_en,
   output logic [ADDR_W-1:0]            bram_wr_addr,
   output logic [DATA_W-1:0]            bram_wr_data,
   input  logic                         bram_wr_ready,
   output logic                         busy,
   output logic                         err_overflow
);

   localparam int LVL    = $clog2(NUM_PE);
   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = PROD_W + LVL;
   localparam int INNER  = NUM_PE - 1;
   localparam int NODES  = 2 * NUM_PE - 1;

   localparam logic [ACC_W-1:0]         C_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0]         C_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic [DATA_W-1:0]        C_RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0]        C_RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]    C_HALF    = (ACC_W+1)'(1) << (FRAC_BITS-1);

   // Tree stored as a heap: node i has children 2i+1 and 2i+2; the leaves are
   // the sign-extended products, every inner node is a register, so each tree
   // level is exactly one pipeline stage and node 0 is the final sum.
   logic signed [SUM_W-1:0]  node_w [NODES];
   logic signed [SUM_W-1:0]  node_q [INNER];

   // Per-stage control; index LVL-1 lines up with node_q[0].
   logic [LVL-1:0]           valid_q;
   logic [LVL-1:0]           close_q;
   logic [ADDR_W-1:0]        addr_q [LVL];

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W:0]    acc_sum;
   logic signed [ACC_W:0]    rnd;
   logic signed [ACC_W:0]    shr;
   logic [DATA_W-1:0]        res_d;
   logic                     open_q;

   logic [ADDR_W-1:0]        fa_q [2];
   logic [DATA_W-1:0]        fd_q [2];
   logic                     wr_ptr_q;
   logic                     rd_ptr_q;
   logic [1:0]               count_q;
   logic [1:0]               count_d;
   logic                     push;
   logic                     pop;
   logic                     full;
   logic                     accept;
   logic                     acc_ready_q;
   logic                     err_q;

   // Assemble the heap view: registered inner nodes plus combinational leaves.
   always_comb begin
      for (int i = 0; i < INNER; i++) begin
         node_w[i] = node_q[i];
      end
      for (int k = 0; k < NUM_PE; k++) begin
         node_w[INNER + k] = SUM_W'($signed(products_in[k*PROD_W +: PROD_W]));
      end
   end

   // Adder tree registers: each inner node sums its two children.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < INNER; i++) begin
            node_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < INNER; i++) begin
            node_q[i] <= node_w[2*i+1] + node_w[2*i+2];
         end
      end
   end

   // Control shift register travelling alongside the tree data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         close_q <= '0;
         for (int s = 0; s < LVL; s++) begin
            addr_q[s] <= '0;
         end
      end else begin
         valid_q[0] <= prod_valid;
         close_q[0] <= neuron_done;
         addr_q[0]  <= out_addr;
         for (int s = 1; s < LVL; s++) begin
            valid_q[s] <= valid_q[s-1];
            close_q[s] <= close_q[s-1];
            addr_q[s]  <= addr_q[s-1];
         end
      end
   end

   // Saturating accumulate, then round-half-up rescale and result saturation.
   always_comb begin
      acc_sum = (ACC_W+1)'(acc_q);
      if (valid_q[LVL-1]) begin
         acc_sum = acc_sum + (ACC_W+1)'(node_q[0]);
      end
      if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
         acc_d = acc_sum[ACC_W] ? C_ACC_MIN : C_ACC_MAX;
      end else begin
         acc_d = acc_sum[ACC_W-1:0];
      end
      rnd = (ACC_W+1)'(acc_d) + C_HALF;
      shr = rnd >>> FRAC_BITS;
      if ((&shr[ACC_W:DATA_W-1]) || (~|shr[ACC_W:DATA_W-1])) begin
         res_d = shr[DATA_W-1:0];
      end else begin
         res_d = shr[ACC_W] ? C_RES_MIN : C_RES_MAX;
      end
`ifdef NEURON_ACC_RELU_EN
      if (res_d[DATA_W-1]) begin
         res_d = '0;
      end
`else
      res_d = res_d;
`endif
   end

   // Accumulator register: a close finalizes acc_d and starts the next neuron at 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         open_q <= 1'b0;
      end else if (close_q[LVL-1]) begin
         acc_q  <= '0;
         open_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (valid_q[LVL-1]) begin
            open_q <= 1'b1;
         end
      end
   end

   // FIFO handshake; a pop frees the head slot in the same cycle a push lands.
   always_comb begin
      push    = close_q[LVL-1];
      pop     = (count_q != 2'd0) && bram_wr_ready;
      full    = (count_q == 2'd2);
      accept  = push && (!full || pop);
      count_d = count_q;
      if (accept && !pop) begin
         count_d = count_q + 2'd1;
      end else if (!accept && pop) begin
         count_d = count_q - 2'd1;
      end
   end

   // Write-back FIFO storage, pointers, ready flag and sticky overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fa_q[0]     <= '0;
         fa_q[1]     <= '0;
         fd_q[0]     <= '0;
         fd_q[1]     <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         acc_ready_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            fa_q[wr_ptr_q] <= addr_q[LVL-1];
            fd_q[wr_ptr_q] <= res_d;
            wr_ptr_q       <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q     <= count_d;
         acc_ready_q <= !full;
         if (push && full && !pop) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bram_wr_en   = (count_q != 2'd0);
   assign bram_wr_addr = fa_q[rd_ptr_q];
   assign bram_wr_data = fd_q[rd_ptr_q];
   assign acc_ready    = acc_ready_q;
   assign err_overflow = err_q;
   assign busy         = (|valid_q) || (|close_q) || open_q || bram_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_neuron_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_neuron_accumulator
// Purpose  : Self-checking bench for neuron_accumulator: directed scenarios
//            with literal expectations plus randomized traffic compared each
//            cycle against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neuron_accumulator;

   localparam int NPE = 16;
   localparam int PW  = 32;

   logic              clk;
   logic              rst;
   logic [NPE*PW-1:0] products_in;
   logic              prod_valid;
   logic              neuron_done;
   logic [15:0]       out_addr;
   logic              acc_ready;
   logic              bram_wr_en;
   logic [15:0]       bram_wr_addr;
   logic [15:0]       bram_wr_data;
   logic              bram_wr_ready;
   logic              busy;
   logic              err_overflow;

   neuron_accumulator dut (
      .clk           (clk),
      .rst           (rst),
      .products_in   (products_in),
      .prod_valid    (prod_valid),
      .neuron_done   (neuron_done),
      .out_addr      (out_addr),
      .acc_ready     (acc_ready),
      .bram_wr_en    (bram_wr_en),
      .bram_wr_addr  (bram_wr_addr),
      .bram_wr_data  (bram_wr_data),
      .bram_wr_ready (bram_wr_ready),
      .busy          (busy),
      .err_overflow  (err_overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      longint      due;
      bit          v;
      bit          c;
      longint      sum;
      logic [15:0] addr;
   } ev_t;
   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   ev_t    pend[$];
   wr_t    fifo_m[$];
   wr_t    wlog[$];
   longint acc_m    = 0;
   bit     open_m   = 0;
   bit     err_m    = 0;
   bit     ready_m  = 0;
   longint cyc      = 0;
   logic        obs_en = 0;
   logic [15:0] obs_a  = 0;
   logic [15:0] obs_d  = 0;

   function automatic longint sat_acc(input longint x);
      longint mx;
      mx = 64'sh1FF_FFFF_FFFF;
      if (x > mx) return mx;
      if (x < -mx - 1) return -mx - 1;
      return x;
   endfunction

   function automatic logic [15:0] finalize(input longint x);
      longint r;
      r = (x + 128) >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`ifdef NEURON_ACC_RELU_EN
      if (r < 0) r = 0;
`endif
      return 16'(r);
   endfunction

   function automatic longint group_sum(input logic [NPE*PW-1:0] p);
      longint s;
      logic [31:0] w;
      s = 0;
      for (int k = 0; k < NPE; k++) begin
         w = p[k*PW +: PW];
         s += longint'($signed(w));
      end
      return s;
   endfunction

   // Model update on each edge, then compare DUT outputs shortly after.
   always @(posedge clk) begin
      if (!rst) begin
         pend.delete();
         fifo_m.delete();
         acc_m   = 0;
         open_m  = 0;
         err_m   = 0;
         ready_m = 0;
      end else begin
         int  sz;
         bit  pp;
         bit  ps;
         wr_t ent;
         sz = fifo_m.size();
         pp = (sz != 0) && bram_wr_ready;
         if (obs_en && bram_wr_ready) begin
            ent.a = obs_a;
            ent.d = obs_d;
            wlog.push_back(ent);
         end
         ps = 0;
         if (pend.size() != 0 && pend[0].due == cyc) begin
            ev_t e;
            longint an;
            e  = pend.pop_front();
            an = sat_acc(acc_m + (e.v ? e.sum : 0));
            if (e.c) begin
               ps     = 1;
               ent.a  = e.addr;
               ent.d  = finalize(an);
               acc_m  = 0;
               open_m = 0;
            end else begin
               acc_m = an;
               if (e.v) open_m = 1;
            end
         end
         if (pp) void'(fifo_m.pop_front());
         if (ps) begin
            if (sz < 2 || pp) fifo_m.push_back(ent);
            else err_m = 1;
         end
         ready_m = (sz != 2);
         if (prod_valid || neuron_done) begin
            ev_t n;
            n.due  = cyc + 4;
            n.v    = prod_valid;
            n.c    = neuron_done;
            n.sum  = prod_valid ? group_sum(products_in) : 0;
            n.addr = out_addr;
            pend.push_back(n);
         end
         cyc++;
      end
      #1;
      chk("wr_en", bram_wr_en, fifo_m.size() != 0);
      if (fifo_m.size() != 0) begin
         chk("wr_addr", bram_wr_addr, fifo_m[0].a);
         chk("wr_data", bram_wr_data, fifo_m[0].d);
      end else if (!rst) begin
         chk("rst_addr", bram_wr_addr, 16'h0);
         chk("rst_data", bram_wr_data, 16'h0);
      end
      chk("acc_ready", acc_ready, ready_m);
      chk("err_overflow", err_overflow, err_m);
      chk("busy", busy, (pend.size() != 0) || open_m || (fifo_m.size() != 0));
      obs_en = bram_wr_en;
      obs_a  = bram_wr_addr;
      obs_d  = bram_wr_data;
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [NPE*PW-1:0] rep(input logic [31:0] v);
      logic [NPE*PW-1:0] r;
      for (int k = 0; k < NPE; k++) r[k*PW +: PW] = v;
      return r;
   endfunction

   task automatic step(input bit pv, input bit nd, input logic [15:0] a,
                       input logic [NPE*PW-1:0] p);
      @(negedge clk);
      prod_valid  = pv;
      neuron_done = nd;
      out_addr    = a;
      products_in = p;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 16'h0, '0);
   endtask

   task automatic chk_one(input string nm, input logic [15:0] a, input logic [15:0] d);
      chk({nm, "_count"}, wlog.size(), 1);
      if (wlog.size() > 0) begin
         chk({nm, "_addr"}, wlog[0].a, a);
         chk({nm, "_data"}, wlog[0].d, d);
      end
   endtask

   function automatic logic [31:0] rprod();
      case ($urandom_range(0, 3))
         0:       return 32'($signed(12'($urandom)));
         1:       return $urandom;
         2:       return ($urandom_range(0, 1) != 0) ? 32'h0001_0000 : 32'hFFFF_0000;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   initial begin
      logic [NPE*PW-1:0] pv;
      rst           = 1'b0;
      prod_valid    = 1'b0;
      neuron_done   = 1'b0;
      out_addr      = 16'h0;
      products_in   = '0;
      bram_wr_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_acc_ready", acc_ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", acc_ready, 1'b1);

      // Single group closed in the same cycle; pin write latency.
      wlog.delete();
      step(1, 1, 16'h0010, rep(32'h0001_0000));
      idle(4);
      chk("single_en_early", bram_wr_en, 1'b0);
      idle(1);
      chk("single_en_on_time", bram_wr_en, 1'b1);
      chk("single_data_now", bram_wr_data, 16'h1000);
      idle(6);
      chk_one("single", 16'h0010, 16'h1000);

      // Four groups then a lone close.
      wlog.delete();
      for (int g = 0; g < 4; g++) step(1, 0, 16'h0, rep(32'h0000_0100));
      step(0, 1, 16'h0003, '0);
      idle(8);
      chk_one("multi", 16'h0003, 16'h0040);

      // Positive saturation.
      wlog.delete();
      step(1, 1, 16'h0020, rep(32'h7FFF_0000));
      idle(8);
      chk_one("sat_pos", 16'h0020, 16'h7FFF);

      // Negative result (ReLU-dependent).
      wlog.delete();
      step(1, 1, 16'h0021, rep(32'hFFFF_0000));
      idle(8);
`ifdef NEURON_ACC_RELU_EN
      chk_one("neg", 16'h0021, 16'h0000);
`else
      chk_one("neg", 16'h0021, 16'hF000);
`endif

      // Rounding boundary.
      wlog.delete();
      pv = '0;
      pv[31:0] = 32'h0000_0080;
      step(1, 1, 16'h0030, pv);
      idle(8);
      chk_one("round_up", 16'h0030, 16'h0001);
      wlog.delete();
      pv[31:0] = 32'h0000_007F;
      step(1, 1, 16'h0031, pv);
      idle(8);
      chk_one("round_down", 16'h0031, 16'h0000);

      // Empty close.
      wlog.delete();
      step(0, 1, 16'h0032, '0);
      idle(8);
      chk_one("empty", 16'h0032, 16'h0000);

      // Accumulator saturation then recovery.
      wlog.delete();
      for (int g = 0; g < 70; g++) step(1, 0, 16'h0, rep(32'h7FFF_FFFF));
      for (int g = 0; g < 64; g++) step(1, 0, 16'h0, rep(32'h8000_0000));
      step(0, 1, 16'h0033, '0);
      idle(8);
      chk_one("acc_sat", 16'h0033, 16'h0000);

      // Backpressure: three back-to-back neurons into a 2-entry FIFO.
      wlog.delete();
      @(negedge clk);
      bram_wr_ready = 1'b0;
      step(1, 1, 16'h0041, rep(32'h0001_0000));
      step(1, 1, 16'h0042, rep(32'h0002_0000));
      step(1, 1, 16'h0043, rep(32'h0003_0000));
      idle(8);
      chk("bp_err", err_overflow, 1'b1);
      chk("bp_ready_low", acc_ready, 1'b0);
      chk("bp_no_writes", wlog.size(), 0);
      @(negedge clk);
      bram_wr_ready = 1'b1;
      idle(6);
      chk("bp_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("bp_first_addr", wlog[0].a, 16'h0041);
         chk("bp_first_data", wlog[0].d, 16'h1000);
         chk("bp_second_addr", wlog[1].a, 16'h0042);
         chk("bp_second_data", wlog[1].d, 16'h2000);
      end
      chk("bp_ready_back", acc_ready, 1'b1);

      // Reset mid-neuron clears the sticky error and aborts the open neuron.
      wlog.delete();
      step(1, 0, 16'h0, rep(32'h0001_0000));
      step(1, 0, 16'h0, rep(32'h0001_0000));
      @(negedge clk);
      prod_valid  = 1'b0;
      rst         = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rst_mid_err_clear", err_overflow, 1'b0);
      step(1, 1, 16'h0050, rep(32'h0001_0000));
      idle(8);
      chk_one("rst_mid", 16'h0050, 16'h1000);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [NPE*PW-1:0] rp;
         bit g;
         for (int k = 0; k < NPE; k++) rp[k*PW +: PW] = rprod();
         @(negedge clk);
         g             = acc_ready && ($urandom_range(0, 3) != 0);
         prod_valid    = g;
         neuron_done   = ($urandom_range(0, 5) == 0);
         out_addr      = 16'($urandom);
         products_in   = rp;
         bram_wr_ready = ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      prod_valid    = 1'b0;
      neuron_done   = 1'b1;
      bram_wr_ready = 1'b1;
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
